shared_main_memory: RTL

Parametrised, multi-channel main-memory model that replaces the separate instruction and data memories behind the pipelined CPU's caches with one shared block-addressed array. It serves NUM_CH cache-side channels through the existing READ/WRITE/BUSYWAIT block handshake, with round-robin arbitration and a programmable access latency. Only one access is in flight at a time. Channel 0 is the instruction cache and channel 1 the data cache in the default build.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/shared_main_memory.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared main-memory package: FSM states,
// default block geometry and a width helper.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  localparam int MEM_ADDR_W  = 28;
  localparam int MEM_BLOCK_W = 128;

  function automatic int clog2w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker; the
// search starts at rr_ptr, owned by the parent.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int GW     = clog2w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [GW-1:0]     rr_ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [GW-1:0]     gnt_idx
);

  // first requester at or after rr_ptr, wrapping
  always_comb begin
    int   c;
    logic found;
    c       = 0;
    found   = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(rr_ptr) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!found && req[c]) begin
        found   = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = GW'(c);
      end
    end
  end

endmodule

// File: rtl/shared_main_memory.sv
// Shared block memory behind the caches:
// round-robin channels, one access in flight.
module shared_main_memory
  import mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int BLOCK_W = MEM_BLOCK_W,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4,
  parameter int NUM_CH  = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_CH-1:0]         READ,
  input  logic [NUM_CH-1:0]         WRITE,
  input  logic [NUM_CH*ADDR_W-1:0]  ADDRESS,
  input  logic [NUM_CH*BLOCK_W-1:0] WRITEDATA,
  output logic [NUM_CH*BLOCK_W-1:0] READDATA,
  output logic [NUM_CH-1:0]         BUSYWAIT
);

  localparam int IW = clog2w(DEPTH);
  localparam int CW = clog2w(LATENCY);
  localparam int GW = clog2w(NUM_CH);

  logic [BLOCK_W-1:0] mem [0:DEPTH-1];

  mem_state_e         state;
  logic [CW-1:0]      cnt;
  logic [GW-1:0]      grant;
  logic [GW-1:0]      rr_ptr;
  logic               op_wr;
  logic [IW-1:0]      idx;
  logic [BLOCK_W-1:0] wdata;

  logic [NUM_CH-1:0]  req;
  logic [NUM_CH-1:0]  gnt_oh;
  logic [GW-1:0]      gnt_idx;
  logic               fire;
  logic               unused_addr;

  assign req         = READ | WRITE;
  assign fire        = (state == ST_ACCESS) && (cnt == '0);
  assign unused_addr = ^ADDRESS;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .GW     (GW)
  ) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  // stall every requester except the one in DONE
  always_comb begin
    BUSYWAIT = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      BUSYWAIT[c] = req[c] &
        ~((state == ST_DONE) && (int'(grant) == c));
    end
  end

  // array write; reset aborts an in-flight commit
  always_ff @(posedge CLK) begin
    if (RESET && fire && op_wr) begin
      mem[idx] <= wdata;
    end
  end

  // transaction FSM with registered read blocks
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      cnt      <= '0;
      grant    <= '0;
      READDATA <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|req) begin
            grant <= gnt_idx;
            op_wr <= |(WRITE & gnt_oh);
            idx   <= ADDRESS[int'(gnt_idx)*ADDR_W +: IW];
            wdata <= WRITEDATA[int'(gnt_idx)*BLOCK_W +: BLOCK_W];
            cnt   <= CW'(LATENCY - 1);
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            if (!op_wr) begin
              READDATA[int'(grant)*BLOCK_W +: BLOCK_W] <= mem[idx];
            end
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (int'(grant) == NUM_CH - 1) rr_ptr <= '0;
          else rr_ptr <= grant + 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
